// File: rtl/coh_bus_arbiter_pkg.sv
// Shared types for the two-CPU coherence bus sequencer and the cache datasel muxes.
package coh_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    RD_MISS = 2'b00,
    WR_MISS = 2'b01,
    INVAL   = 2'b10,
    RSVD    = 2'b11
  } coh_op_t;

  typedef enum logic [2:0] {
    IDLE,
    SNOOP,
    XFER,
    MEM,
    DONE
  } arb_state_t;

  localparam logic SOURCE_DMEM       = 1'b0;
  localparam logic SOURCE_OTHER_PROC = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/coh_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the CPU that did not finish last wins.
module rr_arb2 (
  input  logic req_0,
  input  logic req_1,
  input  logic last_owner,
  output logic valid,
  output logic winner
);

  assign valid  = req_0 | req_1;
  assign winner = (req_0 & req_1) ? ~last_owner : req_1;

endmodule

// File: rtl/coh_bus_arbiter.sv
// Coherence bus sequencer: arbitrate, snoop the non-owner, then forward or hit dmem.
module coh_bus_arbiter
  import coh_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int DMEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              req_1,
  input  logic [1:0]        op_0,
  input  logic [1:0]        op_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic              snoop_hit,
  output logic              grant_0,
  output logic              grant_1,
  output logic              snoop_req,
  output logic              snoop_inval,
  output logic [ADDR_W-1:0] snoop_addr,
  output logic              dmem_rd,
  output logic              dmem_wr,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              src_other,
  output logic              done_0,
  output logic              done_1,
  output logic              busy
);

  arb_state_t        state, state_n;
  coh_op_t           op, op_n;
  logic              owner, owner_n;
  logic              last_owner, last_owner_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              pick_vld, pick_win;

  rr_arb2 u_rr (
    .req_0      (req_0),
    .req_1      (req_1),
    .last_owner (last_owner),
    .valid      (pick_vld),
    .winner     (pick_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op         <= RD_MISS;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      addr       <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_n;
      op         <= op_n;
      owner      <= owner_n;
      last_owner <= last_owner_n;
      addr       <= addr_n;
      cnt        <= cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    op_n         = op;
    owner_n      = owner;
    last_owner_n = last_owner;
    addr_n       = addr;
    cnt_n        = cnt;
    case (state)
      IDLE: if (pick_vld) begin
        owner_n = pick_win;
        op_n    = coh_op_t'(pick_win ? op_1 : op_0);
        addr_n  = pick_win ? addr_1 : addr_0;
        state_n = (op_n == RSVD) ? DONE : SNOOP;
      end
      SNOOP: begin
        cnt_n = CNT_W'(DMEM_LAT - 1);
        case (op)
          RD_MISS: state_n = snoop_hit ? XFER : MEM;
          WR_MISS: state_n = MEM;
          default: state_n = DONE;
        endcase
      end
      XFER: state_n = DONE;
      // Counter holds the remaining strobe cycles after the current one.
      MEM: begin
        if (cnt == '0) state_n = DONE;
        else           cnt_n   = cnt - 1'b1;
      end
      DONE: begin
        last_owner_n = owner;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign grant_0     = busy & ~owner;
  assign grant_1     = busy & owner;
  assign snoop_req   = (state == SNOOP);
  assign snoop_inval = snoop_req & (op != RD_MISS);
  assign snoop_addr  = addr;
  assign dmem_rd     = (state == MEM) & (op == RD_MISS);
  assign dmem_wr     = (state == MEM) & (op == WR_MISS);
  assign dmem_addr   = addr;
  assign src_other   = (state == XFER) ? SOURCE_OTHER_PROC : SOURCE_DMEM;
  assign done_0      = (state == DONE) & ~owner;
  assign done_1      = (state == DONE) & owner;

endmodule

// File: tb/tb_coh_bus_arbiter.sv
// Directed bench for coh_bus_arbiter: transaction table plus tie, fairness and reset sequences.
module tb_coh_bus_arbiter;

  localparam int AW  = 11;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_0 = 1'b0, req_1 = 1'b0;
  logic [1:0]    op_0 = 2'b00, op_1 = 2'b00;
  logic [AW-1:0] addr_0 = '0, addr_1 = '0;
  logic          snoop_hit = 1'b0;
  logic          grant_0, grant_1, snoop_req, snoop_inval, dmem_rd, dmem_wr;
  logic          src_other, done_0, done_1, busy;
  logic [AW-1:0] snoop_addr, dmem_addr;

  coh_bus_arbiter #(.ADDR_W(AW), .DMEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .req_1(req_1), .op_0(op_0), .op_1(op_1),
    .addr_0(addr_0), .addr_1(addr_1), .snoop_hit(snoop_hit),
    .grant_0(grant_0), .grant_1(grant_1),
    .snoop_req(snoop_req), .snoop_inval(snoop_inval), .snoop_addr(snoop_addr),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr),
    .src_other(src_other), .done_0(done_0), .done_1(done_1), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            cpu;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    bit            hit;
    int            lat;
    int            rd;
    int            wr;
    int            xf;
    int            sreq;
    int            sinv;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'(|{grant_0, grant_1, snoop_req, snoop_inval, snoop_addr, dmem_rd,
                  dmem_wr, dmem_addr, src_other, done_0, done_1, busy});
  endfunction

  task automatic run_txn(input vec_t v, input string nm);
    int lat, rd, wr, xf, sreq, sinv, aerr, gerr;
    lat = -1; rd = 0; wr = 0; xf = 0; sreq = 0; sinv = 0; aerr = 0; gerr = 0;
    @(posedge clk); #1;
    if (v.cpu) begin req_1 = 1'b1; op_1 = v.op; addr_1 = v.addr; end
    else       begin req_0 = 1'b1; op_0 = v.op; addr_0 = v.addr; end
    snoop_hit = v.hit;
    @(posedge clk);
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      #1;
      // idle CPU wiggles its op/addr; the owner's latched values must not move
      if (v.cpu) begin op_0 = 2'($urandom); addr_0 = AW'($urandom); end
      else       begin op_1 = 2'($urandom); addr_1 = AW'($urandom); end
      @(negedge clk);
      if (dmem_rd) begin rd++; if (dmem_addr !== v.addr) aerr++; end
      if (dmem_wr) begin wr++; if (dmem_addr !== v.addr) aerr++; end
      if (src_other) xf++;
      if (snoop_req) begin sreq++; if (snoop_addr !== v.addr) aerr++; end
      if (snoop_inval) sinv++;
      if (!busy || (v.cpu ? (!grant_1 || grant_0 || done_0) : (!grant_0 || grant_1 || done_1)))
        gerr++;
      if (v.cpu ? done_1 : done_0) lat = n;
      @(posedge clk);
    end
    #1; req_0 = 1'b0; req_1 = 1'b0;
    @(negedge clk);
    chk({nm, "_lat"},  lat,  v.lat);
    chk({nm, "_rd"},   rd,   v.rd);
    chk({nm, "_wr"},   wr,   v.wr);
    chk({nm, "_xfer"}, xf,   v.xf);
    chk({nm, "_sreq"}, sreq, v.sreq);
    chk({nm, "_sinv"}, sinv, v.sinv);
    chk({nm, "_addr"}, aerr, 0);
    chk({nm, "_gnt"},  gerr, 0);
    chk({nm, "_idle"}, int'(busy), 0);
  endtask

  task automatic run_pair(input string nm);
    int first, second, ovl;
    logic d0, d1;
    first = -1; second = -1; ovl = 0;
    @(posedge clk); #1;
    req_0 = 1'b1; op_0 = 2'b00; addr_0 = 11'h100;
    req_1 = 1'b1; op_1 = 2'b00; addr_1 = 11'h200;
    snoop_hit = 1'b0;
    for (int n = 0; n < 60 && second < 0; n++) begin
      @(negedge clk);
      if (grant_0 && grant_1) ovl++;
      d0 = done_0; d1 = done_1;
      if (d0 || d1) begin
        if (first < 0) first = d0 ? 0 : 1;
        else           second = d0 ? 0 : 1;
      end
      @(posedge clk); #1;
      if (d0) req_0 = 1'b0;
      if (d1) req_1 = 1'b0;
    end
    req_0 = 1'b0; req_1 = 1'b0;
    chk({nm, "_first"},  first,  0);
    chk({nm, "_second"}, second, 1);
    chk({nm, "_ovl"},    ovl,    0);
  endtask

  vec_t vecs[7];
  int   d0, g1, d1, d0b, ovl, nd;
  bit   raise;

  initial begin
    vecs[0] = '{1'b0, 2'b00, 11'h155, 1'b1, 3,     0,   0,   1, 1, 0};
    vecs[1] = '{1'b1, 2'b01, 11'h7FF, 1'b0, 2+LAT, 0,   LAT, 0, 1, 1};
    vecs[2] = '{1'b1, 2'b01, 11'h7FF, 1'b1, 2+LAT, 0,   LAT, 0, 1, 1};
    vecs[3] = '{1'b0, 2'b00, 11'h2A0, 1'b0, 2+LAT, LAT, 0,   0, 1, 0};
    vecs[4] = '{1'b0, 2'b10, 11'h001, 1'b1, 2,     0,   0,   0, 1, 1};
    vecs[5] = '{1'b1, 2'b11, 11'h123, 1'b1, 1,     0,   0,   0, 0, 0};
    vecs[6] = '{1'b1, 2'b00, 11'h000, 1'b1, 3,     0,   0,   1, 1, 0};

    repeat (2) @(negedge clk);
    chk("reset_outs", all_outs(), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", all_outs(), 0);

    // simultaneous pairs first, while last_owner still holds its reset value
    run_pair("tie_a");
    run_pair("tie_b");

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // cpu0 streams INVALs; a single cpu1 request must slot in right after cpu0's done
    @(posedge clk); #1;
    req_0 = 1'b1; op_0 = 2'b10; addr_0 = 11'h3C0;
    op_1 = 2'b00; addr_1 = 11'h0AA; snoop_hit = 1'b1;
    d0 = -1; g1 = -1; d1 = -1; d0b = -1; ovl = 0;
    for (int n = 0; n < 80 && d0b < 0; n++) begin
      @(negedge clk);
      if (grant_0 && grant_1) ovl++;
      raise = grant_0 && !req_1 && d0 < 0;
      if (done_0 && d0 < 0) d0 = n;
      else if (done_0 && d1 >= 0 && d0b < 0) d0b = n;
      if (grant_1 && g1 < 0) g1 = n;
      if (done_1 && d1 < 0) d1 = n;
      @(posedge clk); #1;
      if (raise) req_1 = 1'b1;
      if (done_1) req_1 = 1'b0;
    end
    req_0 = 1'b0; req_1 = 1'b0;
    chk("b2b_d0",   d0,  2);
    chk("b2b_g1",   g1,  d0 + 2);
    chk("b2b_d1",   d1,  g1 + 2);
    chk("b2b_d0b",  d0b, d1 + 3);
    chk("b2b_ovl",  ovl, 0);
    repeat (2) @(negedge clk);
    chk("b2b_idle", int'(busy), 0);

    // reset during the second MEM cycle aborts the write with no done pulse
    @(posedge clk); #1;
    req_0 = 1'b1; op_0 = 2'b01; addr_0 = 11'h0F0; snoop_hit = 1'b0;
    @(posedge clk);
    repeat (3) @(negedge clk);
    chk("rst_mem2_wr", int'(dmem_wr), 1);
    #1 rst_n = 1'b0;
    #1 chk("rst_async_outs", all_outs(), 0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_0 || done_1 || busy) nd++;
    end
    req_0 = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    if (done_0 || done_1 || busy) nd++;
    chk("rst_no_done", nd, 0);
    run_txn(vecs[3], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coh_bus_arbiter.md
Name: coh_bus_arbiter

Overview:
Sequencer and arbiter for the shared two-CPU coherence bus. Accepts read-miss, write-miss and invalidate requests from cpu0/cpu1 and grants the bus to one requester at a time, round-robin on ties. Drives the snoop phase to the non-owning CPU, then either a cache-to-cache transfer or a fixed-latency dmem access. Signals completion to the owner. Sits between the two cache controllers, the snoop ports and the dmem port.

Parameters:
ADDR_W, 11, width of full byte/word address on bus
DMEM_LAT, 4, cycles dmem_rd/dmem_wr held per access; legal 1..15

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req_0  input  1  cpu0 bus request; held with op_0/addr_0 until done_0
req_1  input  1  cpu1 bus request; held with op_1/addr_1 until done_1
op_0  input  2  cpu0 op: 00 RD_MISS, 01 WR_MISS, 10 INVAL, 11 reserved
op_1  input  2  cpu1 op, same encoding
addr_0  input  ADDR_W  cpu0 request address
addr_1  input  ADDR_W  cpu1 request address
snoop_hit  input  1  non-owner holds valid copy; sampled on last SNOOP cycle
grant_0  output  1  cpu0 owns bus
grant_1  output  1  cpu1 owns bus
snoop_req  output  1  non-owner must look up snoop_addr
snoop_inval  output  1  non-owner must invalidate matching block
snoop_addr  output  ADDR_W  latched request address
dmem_rd  output  1  dmem read strobe
dmem_wr  output  1  dmem write strobe (owner's data)
dmem_addr  output  ADDR_W  latched request address
src_other  output  1  owner datasel: 1 other proc, 0 dmem
done_0  output  1  one-cycle completion pulse to cpu0
done_1  output  1  one-cycle completion pulse to cpu1
busy  output  1  state != IDLE

Behaviour:
- Reset (async): state IDLE, last_owner=1 (cpu0 wins first tie), mem counter 0. All outputs 0. Addr outputs 0. Reset mid-transaction aborts it with no done pulse.
- All outputs are decoded from registered state/owner/op/addr; no input-to-output combinational path.
- IDLE: if exactly one req is high, that CPU wins. If both, winner = !last_owner. Latch owner, op, addr at the clock edge. Next state SNOOP, or DONE for op 11. No req: stay IDLE.
- grant_<owner> is high in every non-IDLE state; grant_0 and grant_1 are never both high.
- SNOOP (1 cycle): snoop_req=1; snoop_inval=(op!=RD_MISS); snoop_addr=addr. Transitions:
  - RD_MISS with snoop_hit: XFER.
  - RD_MISS without snoop_hit: MEM with dmem_rd.
  - WR_MISS: MEM with dmem_wr; snoop_hit ignored.
  - INVAL: DONE.
- XFER (1 cycle): src_other=1; owner captures forwarded data.
- MEM: counter loads DMEM_LAT-1 on entry and decrements each cycle. dmem_rd or dmem_wr is held high and dmem_addr is valid for exactly DMEM_LAT cycles. src_other=0. Exit to DONE when count==0.
- DONE (1 cycle): done_<owner>=1; last_owner<=owner; next IDLE.
- Requester drops req the cycle after done. A req seen high in IDLE is always a new request, so back-to-back requests from one CPU cost one IDLE cycle.
- Latency from the accept edge to the done pulse:
  - RD hit: 3 cycles.
  - RD/WR miss: 2+DMEM_LAT cycles.
  - INVAL: 2 cycles.
  - op 11: 1 cycle, with no snoop or dmem activity.
- A request from the non-owner arriving mid-transaction waits. It wins at the next IDLE because last_owner has been updated, so neither CPU starves.
- Changes on a losing CPU's op/addr during another's transaction are ignored.

Decomposition:
- Package common: coh_op_t enum (RD_MISS, WR_MISS, INVAL, RSVD); arb_state_t enum (IDLE, SNOOP, XFER, MEM, DONE); SOURCE_DMEM/SOURCE_OTHER_PROC constants, shared with the cache datasel muxes.
- One sub-module, rr_arb2: combinational 2-way round-robin pick (inputs req_0, req_1, last_owner; outputs valid, winner). Instantiated once in IDLE decode. The state machine, latches and counter stay in the top.

Test Plan:
- Single RD_MISS from cpu0, addr 0x155, snoop_hit=1 -> grant_0 for 3 cycles; snoop_req/snoop_addr=0x155 in cycle 1; src_other=1 in cycle 2; done_0 in cycle 3; dmem_rd never high.
- cpu1 WR_MISS addr 0x7FF, DMEM_LAT=4 -> snoop_inval=1 for 1 cycle; dmem_wr high exactly 4 cycles with dmem_addr=0x7FF; done_1 6 cycles after accept.
- req_0 and req_1 asserted together after reset, both RD_MISS, hit=0 -> cpu0 served first, then cpu1. Repeat the simultaneous pair -> cpu0 first again, since last_owner=1 after cpu1 finishes.
- cpu0 issues continuous back-to-back INVALs while cpu1 requests once -> cpu1 granted immediately after cpu0's current done; grant_0 and grant_1 never both high.
- Reset asserted during MEM cycle 2 -> all outputs 0 asynchronously; no done pulse; after release, a fresh request completes normally.
- op 11 from cpu1 -> done_1 one cycle after accept; snoop_req, dmem_rd and dmem_wr stay 0.
